// File: rtl/updown_pkg.sv
// updown_pkg: shared encodings, widths, FSM states and LFSR taps for the up/down game.
package updown_pkg;
    localparam int NUM_W = 7;
    localparam logic [1:0] RES_NONE    = 2'b00;
    localparam logic [1:0] RES_UP      = 2'b01;
    localparam logic [1:0] RES_DOWN    = 2'b10;
    localparam logic [1:0] RES_CORRECT = 2'b11;
    // x^7 + x^6 + 1: feedback is bit6 ^ bit5
    localparam logic [NUM_W-1:0] LFSR_TAPS = 7'h60;
    typedef enum logic [2:0] {IDLE, GEN, PLAY, WIN, LOSE} state_t;
endpackage

// File: rtl/lfsr7.sv
// lfsr7: free-running 7-bit Fibonacci LFSR with synchronous reload of SEED.
module lfsr7 import updown_pkg::*; #(
    parameter logic [NUM_W-1:0] SEED = 7'h5A
) (
    input  logic             clk,
    input  logic             reset,
    output logic [NUM_W-1:0] lfsr
);
    logic [NUM_W-1:0] lfsr_q, lfsr_d;
    always_comb lfsr_d = {lfsr_q[NUM_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    always_ff @(posedge clk) lfsr_q <= reset ? SEED : lfsr_d;
    assign lfsr = lfsr_q;
endmodule

// File: rtl/updown_game_ctrl.sv
// updown_game_ctrl: draws the secret, evaluates guess verdicts and declares win/lose.
// Define ATTEMPT_LIMIT_EN to enforce MAX_TRIES wrong guesses before LOSE.
module updown_game_ctrl import updown_pkg::*; #(
    parameter logic [NUM_W-1:0] MIN_NUM   = 7'd1,
    parameter logic [NUM_W-1:0] MAX_NUM   = 7'd99,
    parameter logic [3:0]       MAX_TRIES = 4'd7,
    parameter logic [NUM_W-1:0] LFSR_SEED = 7'h5A
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             guess_trigger,
    input  logic [1:0]       comparison_result,
    output logic [NUM_W-1:0] actual_number,
    output logic             game_active,
    output logic             win,
    output logic             lose,
    output logic [3:0]       attempts
);
`ifdef ATTEMPT_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif
    state_t           state_q, state_d;
    logic [NUM_W-1:0] lfsr, actual_q, actual_d;
    logic [3:0]       attempts_q, attempts_d;
    logic             pend_q, pend_d;
    logic             game_active_q, win_q, lose_q;
    logic             in_range, wrong;

    lfsr7 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .reset(reset), .lfsr(lfsr));

    assign in_range = (lfsr >= MIN_NUM) && (lfsr <= MAX_NUM);
    assign wrong    = (comparison_result == RES_UP) || (comparison_result == RES_DOWN);

    always_comb begin
        state_d    = state_q;
        actual_d   = actual_q;
        attempts_d = attempts_q;
        pend_d     = 1'b0;
        case (state_q)
            IDLE: state_d = start ? GEN : IDLE;
            GEN: if (in_range) begin
                actual_d   = lfsr;
                attempts_d = 4'd0;
                state_d    = PLAY;
            end
            // start aborts the game and discards any pending verdict
            PLAY: if (start) state_d = GEN;
            else if (pend_q) begin
                attempts_d = (attempts_q == 4'hF) ? 4'hF : attempts_q + 4'd1;
                if (comparison_result == RES_CORRECT) state_d = WIN;
                else if (LIMIT_EN && wrong && attempts_d == MAX_TRIES) state_d = LOSE;
            end
            else pend_d = guess_trigger;
            WIN, LOSE: state_d = start ? GEN : state_q;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            actual_q      <= '0;
            attempts_q    <= '0;
            pend_q        <= 1'b0;
            game_active_q <= 1'b0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            actual_q      <= actual_d;
            attempts_q    <= attempts_d;
            pend_q        <= pend_d;
            game_active_q <= state_d == PLAY;
            win_q         <= state_d == WIN;
            lose_q        <= state_d == LOSE;
        end
    end

    assign actual_number = actual_q;
    assign attempts      = attempts_q;
    assign game_active   = game_active_q;
    assign win           = win_q;
    assign lose          = lose_q;
endmodule

// File: tb/tb_updown_game_ctrl.sv
// tb_updown_game_ctrl: directed checks of game flow, verdict timing, abort and reset.
module tb_updown_game_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       guess_trigger = 1'b0;
    logic [1:0] comparison_result = 2'b00;
    logic [6:0] actual_number;
    logic       game_active, win, lose;
    logic [3:0] attempts;
    logic [6:0] m;
    logic [6:0] e;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    updown_game_ctrl #(.MAX_TRIES(4'd3)) dut (
        .clk(clk), .reset(reset), .start(start), .guess_trigger(guess_trigger),
        .comparison_result(comparison_result), .actual_number(actual_number),
        .game_active(game_active), .win(win), .lose(lose), .attempts(attempts)
    );

    // reference LFSR: x^7+x^6+1 from seed 5A
    always @(posedge clk) m <= reset ? 7'h5A : {m[5:0], m[6] ^ m[5]};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ga, input logic w, input logic l, input logic [3:0] a);
        chk({tag, "_active"}, game_active, ga);
        chk({tag, "_win"}, win, w);
        chk({tag, "_lose"}, lose, l);
        chk({tag, "_attempts"}, attempts, a);
    endtask

    task automatic wait_play(output logic [6:0] num);
        bit done = 0;
        num = 7'd0;
        chk("gen_inactive", game_active, 1'b0);
        for (int i = 0; i < 130 && !done; i++) begin
            if (m >= 7'd1 && m <= 7'd99) begin
                num = m;
                done = 1;
            end
            @(negedge clk);
        end
        chk("play_active", game_active, 1'b1);
        chk("play_number", actual_number, num);
        chk("play_attempts", attempts, 0);
    endtask

    task automatic start_game(output logic [6:0] num);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_play(num);
    endtask

    task automatic guess(input logic [1:0] r);
        guess_trigger = 1'b1;
        @(negedge clk);
        guess_trigger = 1'b0;
        comparison_result = r;
        @(negedge clk);
        comparison_result = 2'b00;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_number", actual_number, 0);
        chk_out("rst", 0, 0, 0, 0);
        reset = 1'b0;
        start_game(e);
        chk("first_secret", actual_number, 7'd53);

        comparison_result = 2'b11;
        @(negedge clk);
        comparison_result = 2'b00;
        chk_out("stray_result", 1, 0, 0, 0);
        guess(2'b01);
        chk_out("g1", 1, 0, 0, 1);
        guess(2'b10);
        chk_out("g2", 1, 0, 0, 2);
        guess(2'b11);
        chk_out("g3_win", 0, 1, 0, 3);
        chk("win_number", actual_number, 7'd53);
        guess(2'b11);
        chk_out("win_ignore", 0, 1, 0, 3);

        start_game(e);
        guess(2'b01);
        guess(2'b10);
        guess(2'b01);
`ifdef ATTEMPT_LIMIT_EN
        chk_out("limit_lose", 0, 0, 1, 3);
        guess(2'b11);
        chk_out("lose_ignore", 0, 0, 1, 3);
`else
        chk_out("nolimit", 1, 0, 0, 3);
        guess(2'b00);
        chk_out("nolimit_none", 1, 0, 0, 4);
`endif

        start_game(e);
        guess_trigger = 1'b1;
        @(negedge clk);
        comparison_result = 2'b11;
        @(negedge clk);
        guess_trigger = 1'b0;
        comparison_result = 2'b00;
        chk_out("double_trig", 0, 1, 0, 1);
        @(negedge clk);
        chk_out("double_trig_hold", 0, 1, 0, 1);

        start_game(e);
        guess(2'b00);
        chk_out("none_counted", 1, 0, 0, 1);
        guess_trigger = 1'b1;
        @(negedge clk);
        guess_trigger = 1'b0;
        start = 1'b1;
        comparison_result = 2'b11;
        @(negedge clk);
        start = 1'b0;
        comparison_result = 2'b00;
        chk("abort_no_win", win, 1'b0);
        wait_play(e);

        guess(2'b11);
        chk_out("pre_rst_win", 0, 1, 0, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_win_number", actual_number, 0);
        chk_out("rst_win", 0, 0, 0, 0);
        reset = 1'b0;
        start_game(e);
        chk("reseed_secret", actual_number, 7'd53);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mid_gen", game_active, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_gen_number", actual_number, 0);
        chk_out("rst_gen", 0, 0, 0, 0);
        reset = 1'b0;
        start_game(e);
        chk("reseed_secret2", actual_number, 7'd53);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
